// File: rtl/bcd_display_converter.sv
// ---------------------------------------------------------------------------
// bcd_display_converter
//
// Purpose:
//   Converts the unsigned binary accumulator value into packed decimal BCD
//   digits so the HexDriver instances show the running sum in decimal.
//   The conversion uses the iterative shift-add-3 ("double dabble") method,
//   retiring one input bit per clock. A leading-zero blank mask is derived
//   from the published digits, and a Start/Ready/Done handshake lets the
//   control unit fire one conversion per accumulate.
//
// Ports:
//   Clk     in   1          system clock, all state changes on rising edge
//   Reset   in   1          synchronous active-high reset, overrides Start
//   Start   in   1          conversion request, accepted only while Ready=1
//   Bin_In  in   WIDTH      binary value, sampled on the accepting edge only
//   Ready   out  1          idle and able to accept Start
//   Done    out  1          one-cycle pulse, BCD_Out holds the new result
//   BCD_Out out  4*DIGITS   packed digits, digit i in bits [4i+3:4i]
//   Blank   out  DIGITS     bit i set when digit i is a leading zero
//
// Parameters:
//   WIDTH   binary input width (default 17, carry-out in bit 16)
//   DIGITS  number of BCD digits; 10^DIGITS must exceed 2^WIDTH - 1
// ---------------------------------------------------------------------------
module bcd_display_converter #(
  parameter int WIDTH  = 17,
  parameter int DIGITS = 6
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic [WIDTH-1:0]      Bin_In,
  output logic                  Ready,
  output logic                  Done,
  output logic [4*DIGITS-1:0]   BCD_Out,
  output logic [DIGITS-1:0]     Blank
);

  localparam int BCD_W = 4 * DIGITS;
  // Counter must be able to hold WIDTH itself, not just WIDTH-1.
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;

  logic [WIDTH-1:0]   shift_reg;
  logic [BCD_W-1:0]   work_reg;
  logic [CNT_W-1:0]   count;
  logic [BCD_W-1:0]   bcd_reg;

  logic [BCD_W-1:0]   adjusted;
  logic [BCD_W-1:0]   shifted;
  logic               last_iter;
  logic               accept;

  logic [DIGITS-1:0]  blank_mask;
  logic               zero_above;

  // A request is only taken while idle; Start in any other state is dropped.
  assign accept    = (state == IDLE) && Start;
  assign last_iter = (count == CNT_W'(1));

  // Add-3 correction: every digit that would reach 10 or more after the
  // doubling shift is pre-biased by 3. Each digit is handled independently
  // with no carry into its neighbour; 9 + 3 = 12 so 4 bits always suffice.
  always_comb begin
    adjusted = work_reg;
    for (int i = 0; i < DIGITS; i++) begin
      if (work_reg[4*i +: 4] >= 4'd5) begin
        adjusted[4*i +: 4] = work_reg[4*i +: 4] + 4'd3;
      end
    end
  end

  // The binary MSB moves into the bottom of the BCD working register as
  // the combined {working, shift} pair shifts left by one.
  assign shifted = {adjusted[BCD_W-2:0], shift_reg[WIDTH-1]};

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. DONE lasts exactly one cycle and returns to IDLE
  // regardless of Start.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (Start) begin
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (last_iter) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath registers. The published result is written only on the final
  // iteration so the display never shows partially converted digits.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      shift_reg <= '0;
      work_reg  <= '0;
      count     <= '0;
      bcd_reg   <= '0;
    end else begin
      if (accept) begin
        shift_reg <= Bin_In;
        work_reg  <= '0;
        count     <= CNT_W'(WIDTH);
      end else if (state == SHIFT) begin
        shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
        work_reg  <= shifted;
        count     <= count - CNT_W'(1);
        if (last_iter) begin
          bcd_reg <= shifted;
        end
      end
    end
  end

  // Leading-zero mask: scanning down from the top digit, a digit is blank
  // while it and every digit above it are zero. Digit 0 always shows so a
  // zero result still displays a single "0".
  always_comb begin
    blank_mask = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      zero_above    = zero_above && (bcd_reg[4*i +: 4] == 4'd0);
      blank_mask[i] = zero_above;
    end
  end

  assign Ready   = (state == IDLE);
  assign Done    = (state == DONE);
  assign BCD_Out = bcd_reg;
  assign Blank   = blank_mask;

endmodule

// File: tb/tb_bcd_display_converter.sv
// ---------------------------------------------------------------------------
// tb_bcd_display_converter
//
// Scoreboard bench for bcd_display_converter. A cycle-level reference model
// tracks when the converter is busy and which value it is converting; the
// expected decimal result is formed with plain division. A monitor on the
// falling edge compares handshake and display outputs every cycle and pops
// the scoreboard whenever the DUT raises Done.
// ---------------------------------------------------------------------------
module tb_bcd_display_converter;

  localparam int WIDTH  = 17;
  localparam int DIGITS = 6;
  localparam int LATENCY = WIDTH + 1;

  logic                 Clk;
  logic                 Reset;
  logic                 Start;
  logic [WIDTH-1:0]     Bin_In;
  logic                 Ready;
  logic                 Done;
  logic [4*DIGITS-1:0]  BCD_Out;
  logic [DIGITS-1:0]    Blank;

  int tests;
  int fails;
  int busy_left;
  int shown_value;
  int exp_q[$];
  bit check_en;

  bcd_display_converter #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .Start   (Start),
    .Bin_In  (Bin_In),
    .Ready   (Ready),
    .Done    (Done),
    .BCD_Out (BCD_Out),
    .Blank   (Blank)
  );

  // 10 ns clock.
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Decimal digits of a value, packed four bits per digit.
  function automatic logic [31:0] toBcd(input int value);
    logic [31:0] r;
    int v;
    r = '0;
    v = value;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Digit i is blank when the value is smaller than 10^i (i > 0).
  function automatic logic [31:0] toBlank(input int value);
    logic [31:0] r;
    int p;
    r = '0;
    p = 1;
    for (int i = 1; i < DIGITS; i++) begin
      p = p * 10;
      r[i] = (value < p);
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: after an accepted Start the converter is busy for
  // LATENCY cycles, raising Done in the last of them, at which point the
  // display takes the value sampled on the accepting edge.
  always @(posedge Clk) begin
    if (Reset) begin
      busy_left   <= 0;
      shown_value <= 0;
      exp_q.delete();
    end else if (busy_left == 0) begin
      if (Start) begin
        exp_q.push_back(int'(Bin_In));
        busy_left <= LATENCY;
      end
    end else begin
      busy_left <= busy_left - 1;
      if (busy_left == 2 && exp_q.size() > 0) begin
        shown_value <= exp_q[0];
      end
    end
  end

  // Monitor: per-cycle handshake/display checks plus scoreboard pop on Done.
  always @(negedge Clk) begin
    if (check_en) begin
      checkOutput("ready", 32'(Ready), 32'(busy_left == 0));
      checkOutput("done", 32'(Done), 32'(busy_left == 1));
      checkOutput("bcd_hold", 32'(BCD_Out), toBcd(shown_value));
      checkOutput("blank", 32'(Blank), toBlank(shown_value));
      if (Done) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL scoreboard: Done with BCD_Out %h but nothing expected", BCD_Out);
        end else begin
          int v;
          v = exp_q.pop_front();
          checkOutput("result", 32'(BCD_Out), toBcd(v));
          checkOutput("result_blank", 32'(Blank), toBlank(v));
        end
      end
    end
  end

  task automatic waitIdle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 4 * LATENCY; i++) begin
      @(negedge Clk);
      if (busy_left == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("[TB] FAIL idle_timeout: busy %0d required 0", busy_left);
    end
  endtask

  // One Start pulse for one cycle, then wait for the conversion to finish.
  task automatic applyStimulus(input int value);
    @(negedge Clk);
    Start  = 1'b1;
    Bin_In = WIDTH'(value);
    @(negedge Clk);
    Start  = 1'b0;
    Bin_In = WIDTH'($urandom);
    waitIdle();
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    check_en = 1'b0;
    Reset    = 1'b1;
    Start    = 1'b0;
    Bin_In   = '0;

    repeat (2) @(posedge Clk);
    #1 check_en = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;

    // Boundary values.
    applyStimulus(0);
    applyStimulus(131071);
    applyStimulus(99999);
    applyStimulus(1234);

    // Second Start while busy must be ignored.
    @(negedge Clk);
    Start  = 1'b1;
    Bin_In = WIDTH'(42);
    @(negedge Clk);
    Start  = 1'b0;
    repeat (3) @(negedge Clk);
    Start  = 1'b1;
    Bin_In = WIDTH'(7);
    @(negedge Clk);
    Start  = 1'b0;
    waitIdle();

    // Reset mid-conversion aborts it, then a fresh conversion works.
    @(negedge Clk);
    Start  = 1'b1;
    Bin_In = WIDTH'(500);
    @(negedge Clk);
    Start  = 1'b0;
    repeat (7) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    applyStimulus(500);

    // Randomized values.
    for (int n = 0; n < 20; n++) begin
      applyStimulus(int'($urandom_range(0, 131071)));
    end

    // Start held high with Bin_In changing every cycle.
    @(negedge Clk);
    Start  = 1'b1;
    Bin_In = WIDTH'(131000);
    for (int n = 0; n < 5 * (LATENCY + 1); n++) begin
      @(negedge Clk);
      Bin_In = Bin_In + 1'b1;
    end
    Start = 1'b0;
    waitIdle();

    repeat (3) @(negedge Clk);
    checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bcd_display_converter.md
Name: bcd_display_converter

Overview:
- Downstream stage of the lab3 accumulator datapath.
- Takes the 17-bit register value (carry-out in bit 16) and converts it to packed decimal BCD digits with an iterative shift-add-3 (double-dabble) engine, one bit per clock.
- Digits feed the HexDriver instances, so the accumulated sum is shown in decimal (max 131071) instead of hex.
- Also produces a leading-zero blank mask and a start/ready/done handshake, so the control unit fires one conversion per accumulate.

Parameters:
- WIDTH, 17, bit width of the binary input.
- DIGITS, 6, number of BCD output digits. Must satisfy 10^DIGITS > 2^WIDTH - 1.

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  request a conversion of Bin_In; accepted only when Ready=1.
- Bin_In  input  WIDTH  unsigned binary value, sampled only on the accepting edge.
- Ready  output  1  high when idle and able to accept Start.
- Done  output  1  single-cycle pulse: BCD_Out holds the new result.
- BCD_Out  output  4*DIGITS  packed digits; digit i in bits [4i+3:4i]; digit 0 is least significant.
- Blank  output  DIGITS  bit i = 1 when digit i is a leading zero; bit 0 is always 0.

Behaviour:
- Reset:
  - Synchronous, active-high; overrides Start.
  - Next state is IDLE, with BCD_Out=0, Done=0, Ready=1, shift and working registers 0, bit counter 0.
  - Blank becomes {1..1,0}, derived from the zeroed BCD_Out.
  - Reset mid-conversion aborts it; no Done is produced.
- FSM states are IDLE, SHIFT and DONE. Ready = (state==IDLE).
- IDLE:
  - On an edge with Start=1, latch Bin_In into the shift register, clear the BCD working register, set counter=WIDTH, and go to SHIFT.
  - Otherwise stay in IDLE; BCD_Out holds its value.
- SHIFT, one iteration per edge:
  - For every working digit >= 5, add 3 to that digit.
  - Shift {working, shift} left by 1; the shift register MSB enters working bit 0.
  - Decrement the counter.
  - On the iteration where counter==1, write the final working value into BCD_Out and go to DONE.
- DONE:
  - Done=1 for exactly this one cycle; Ready=0.
  - The next edge returns to IDLE unconditionally.
  - Start is ignored in this state.
- Timing:
  - Start is accepted at edge E0.
  - SHIFT iterations occur at edges E1..E(WIDTH).
  - BCD_Out updates and Done rises after edge E(WIDTH); Ready returns after edge E(WIDTH+1).
  - With defaults: 17 shift cycles, Done during cycle 18, one conversion per 19 cycles when Start is held high.
- Input handling:
  - Start while Ready=0 is ignored, with no queuing.
  - Bin_In changes after the accepting edge do not affect the result.
- BCD_Out changes only at the transition into DONE or on reset. It never shows intermediate working values.
- Blank logic is combinational from BCD_Out: Blank[i] = 1 iff i > 0 and digits i..DIGITS-1 are all zero.
- Arithmetic:
  - Digit add-3 is 4-bit with no carry between digits; its result is never > 15.
  - No overflow is possible given the DIGITS constraint.

Test Plan:
- Reset, then Start with Bin_In=0 -> Ready low for 18 cycles; Done pulses once after edge 17; BCD_Out=0x000000; Blank=6'b111110.
- Start with Bin_In=17'h1FFFF (131071) -> BCD_Out=0x131071; Blank=6'b000000; Done width exactly 1 cycle.
- Start with Bin_In=99999 -> BCD_Out=0x099999, Blank=6'b100000. Then Bin_In=1234 -> BCD_Out=0x001234, Blank=6'b110000.
- Start with Bin_In=42, then at cycle 5 change Bin_In=7 and pulse Start -> second Start ignored; result 0x000042; one Done only.
- Start with Bin_In=500; assert Reset at cycle 9 -> next cycle BCD_Out=0, Ready=1, no Done. A fresh Start with 500 then yields 0x000500.
- Hold Start=1 continuously while incrementing Bin_In every cycle -> Done every 19 cycles. Each result equals the Bin_In value present at its accepting edge.
